coin_credit_unit: RTL and testbench

Front-end stage between the coin acceptor and the vend-control FSM. It synchronises and debounces the raw coin-acceptor pulse, counts accepted coins into a saturating credit register, and drives credit_ok to the vend FSM in place of a raw coin line. Credit is deducted on the vend FSM's vend_done pulse, which fires when the cam cycle completes. The block also inhibits the acceptor at maximum credit and flags a jammed (stuck-high) acceptor.

---
 rtl/soda_pkg.sv | 22 ++
 rtl/coin_credit_if.sv | 23 ++
 rtl/coin_debouncer.sv | 49 ++++
 rtl/coin_credit_unit.sv | 127 ++++++++++++
 tb/tb_coin_credit_unit.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/soda_pkg.sv
// Shared types and constants for the coin front-end: coin FSM encoding and a
// constant-foldable ceil(log2) used to size counters and the credit register.
package soda_pkg;

  typedef enum logic [1:0] {
    C_LOW  = 2'd0,
    C_HIGH = 2'd1,
    C_JAM  = 2'd2
  } coin_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/coin_credit_if.sv
// Coin-acceptor / vend-FSM side signals of the credit unit, grouped as one bundle.
interface coin_credit_if #(
  parameter int CW = 4
);
  logic          coin_in;
  logic          vend_done;
  logic          credit_clear;
  logic          credit_ok;
  logic [CW-1:0] credit_count;
  logic          coin_event;
  logic          accept_inhibit;
  logic          jam;

  modport master (
    output coin_in, vend_done, credit_clear,
    input  credit_ok, credit_count, coin_event, accept_inhibit, jam
  );

  modport slave (
    input  coin_in, vend_done, credit_clear,
    output credit_ok, credit_count, coin_event, accept_inhibit, jam
  );
endinterface

// File: rtl/coin_debouncer.sv
// Two-flop synchroniser followed by a stability counter: the debounced level
// only follows the synchronised input after DEBOUNCE_CYCLES consecutive disagreements.
module coin_debouncer
  import soda_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_in,
  output logic db_out
);

  localparam int DW = (clog2(DEBOUNCE_CYCLES) < 1) ? 1 : clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_db;
  logic [DW-1:0] r_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= raw_in;
      r_s2 <= r_s1;
    end
  end

  // Any cycle of agreement restarts the count, so short glitches never land.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_db  <= 1'b0;
      r_cnt <= '0;
    end else if (r_s2 == r_db) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_db  <= r_s2;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DW'(1);
    end
  end

  assign db_out = r_db;

endmodule

// File: rtl/coin_credit_unit.sv
// Coin front-end: debounced coin detection, jam watchdog and saturating credit
// with vend deduction; all outputs to the acceptor and vend FSM are registered.
module coin_credit_unit
  import soda_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int JAM_CYCLES      = 25000000,
  parameter int PRICE_PULSES    = 1,
  parameter int MAX_CREDIT      = 15
) (
  input  logic          clock,
  input  logic          reset,
  coin_credit_if.slave  bus
);

  localparam int CW = clog2(MAX_CREDIT + 1);
  localparam int JW = (clog2(JAM_CYCLES) < 1) ? 1 : clog2(JAM_CYCLES);
  localparam logic [CW-1:0] MAX_C    = CW'(MAX_CREDIT);
  localparam logic [CW-1:0] PRICE_C  = CW'(PRICE_PULSES);
  localparam logic [JW-1:0] JAM_LAST = JW'(JAM_CYCLES - 1);

  logic          w_db;
  coin_state_e   r_state;
  coin_state_e   w_state_next;
  logic [JW-1:0] r_jam_cnt;
  logic [JW-1:0] w_jam_cnt_next;
  logic          w_coin_evt;
  logic          w_inc;
  logic          w_dec;
  logic [CW-1:0] w_credit_next;
  logic [CW-1:0] r_credit;
  logic          r_credit_ok;
  logic          r_coin_event;
  logic          r_inhibit;
  logic          r_jam;

  coin_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock  (clock),
    .reset  (reset),
    .raw_in (bus.coin_in),
    .db_out (w_db)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= C_LOW;
      r_jam_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_jam_cnt <= w_jam_cnt_next;
    end
  end

  // C_LOW only re-arms after db has been seen low, so one coin per debounced pulse.
  always_comb begin
    w_state_next   = r_state;
    w_jam_cnt_next = r_jam_cnt;
    w_coin_evt     = 1'b0;
    case (r_state)
      C_LOW: begin
        if (w_db) begin
          w_state_next   = C_HIGH;
          w_jam_cnt_next = '0;
          w_coin_evt     = 1'b1;
        end else begin
          w_state_next = C_LOW;
        end
      end
      C_HIGH: begin
        if (!w_db) begin
          w_state_next = C_LOW;
        end else if (r_jam_cnt == JAM_LAST) begin
          w_state_next = C_JAM;
        end else begin
          w_jam_cnt_next = r_jam_cnt + JW'(1);
        end
      end
      C_JAM: begin
        if (!w_db) begin
          w_state_next = C_LOW;
        end else begin
          w_state_next = C_JAM;
        end
      end
      default: begin
        w_state_next   = C_LOW;
        w_jam_cnt_next = '0;
      end
    endcase
  end

  // Saturation and underflow tests use pre-update credit so a coin and a vend can share a cycle.
  always_comb begin
    w_inc = w_coin_evt && (r_credit < MAX_C);
    w_dec = bus.vend_done && (r_credit >= PRICE_C);
    if (bus.credit_clear) begin
      w_credit_next = '0;
    end else begin
      w_credit_next = r_credit + (w_inc ? CW'(1) : CW'(0)) - (w_dec ? PRICE_C : CW'(0));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_credit     <= '0;
      r_credit_ok  <= 1'b0;
      r_coin_event <= 1'b0;
      r_inhibit    <= 1'b0;
      r_jam        <= 1'b0;
    end else begin
      r_credit     <= w_credit_next;
      r_credit_ok  <= (w_credit_next >= PRICE_C);
      r_coin_event <= w_coin_evt;
      r_inhibit    <= (w_credit_next == MAX_C) || (w_state_next == C_JAM);
      r_jam        <= (w_state_next == C_JAM);
    end
  end

  assign bus.credit_count   = r_credit;
  assign bus.credit_ok      = r_credit_ok;
  assign bus.coin_event     = r_coin_event;
  assign bus.accept_inhibit = r_inhibit;
  assign bus.jam            = r_jam;

endmodule

// File: tb/tb_coin_credit_unit.sv
// Scoreboarded bench for coin_credit_unit with shortened debounce/jam timing.
module tb_coin_credit_unit;

  localparam int DEB   = 4;
  localparam int JAM   = 20;
  localparam int PRICE = 2;
  localparam int MAXC  = 5;
  localparam int CW    = 3;

  typedef struct {
    int edge_n;
    int credit;
    int ok;
    int inh;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   total    = 0;
  int   bad      = 0;
  int   cyc      = 0;
  int   m_credit = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clock = ~clock;

  coin_credit_if #(.CW(CW)) bus ();

  coin_credit_unit #(
    .DEBOUNCE_CYCLES(DEB),
    .JAM_CYCLES     (JAM),
    .PRICE_PULSES   (PRICE),
    .MAX_CREDIT     (MAXC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input int exp_jam);
    check_eq({tag, "_credit"}, int'(bus.credit_count), m_credit);
    check_eq({tag, "_ok"}, int'(bus.credit_ok), int'(m_credit >= PRICE));
    check_eq({tag, "_inh"}, int'(bus.accept_inhibit), int'((m_credit == MAXC) || (exp_jam != 0)));
    check_eq({tag, "_jam"}, int'(bus.jam), exp_jam);
  endtask

  // Model one accepted coin whose first sampling edge is k.
  task automatic expect_coin(input int k, input bit with_vend);
    exp_t e;
    int inc;
    int dec;
    inc = (m_credit < MAXC) ? 1 : 0;
    dec = (with_vend && (m_credit >= PRICE)) ? PRICE : 0;
    m_credit = m_credit + inc - dec;
    e.edge_n = k + DEB + 2;
    e.credit = m_credit;
    e.ok     = int'(m_credit >= PRICE);
    e.inh    = int'(m_credit == MAXC);
    sb.push_back(e);
  endtask

  task automatic coin_pulse(input string tag, input int len, input bit with_vend);
    int k;
    @(negedge clock);
    bus.coin_in = 1'b1;
    k = cyc + 1;
    if (len >= DEB) expect_coin(k, with_vend);
    for (int i = 0; i < len; i++) begin
      if (with_vend && i == DEB + 2) bus.vend_done = 1'b1;
      @(negedge clock);
      bus.vend_done = 1'b0;
    end
    bus.coin_in = 1'b0;
    repeat (8) @(negedge clock);
    check_eq({tag, "_evt_pending"}, sb.size(), 0);
  endtask

  task automatic vend_pulse(input string tag);
    @(negedge clock);
    bus.vend_done = 1'b1;
    @(negedge clock);
    bus.vend_done = 1'b0;
    if (m_credit >= PRICE) m_credit = m_credit - PRICE;
    check_outputs(tag, 0);
  endtask

  task automatic clear_pulse(input string tag);
    @(negedge clock);
    bus.credit_clear = 1'b1;
    @(negedge clock);
    bus.credit_clear = 1'b0;
    m_credit = 0;
    check_outputs(tag, 0);
  endtask

  // Every coin_event must match the oldest expected coin, cycle-exact.
  always @(negedge clock) begin
    if (!reset && bus.coin_event) begin
      check_eq("evt_expected", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check_eq("evt_edge", cyc, mon_e.edge_n);
        check_eq("evt_credit", int'(bus.credit_count), mon_e.credit);
        check_eq("evt_ok", int'(bus.credit_ok), mon_e.ok);
        check_eq("evt_inh", int'(bus.accept_inhibit), mon_e.inh);
      end
    end
  end

  initial begin
    int k;
    reset            = 1'b1;
    bus.coin_in      = 1'b0;
    bus.vend_done    = 1'b0;
    bus.credit_clear = 1'b0;
    #1;
    check_outputs("reset", 0);
    check_eq("reset_evt", int'(bus.coin_event), 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    coin_pulse("glitch", DEB - 1, 1'b0);
    check_outputs("glitch", 0);

    coin_pulse("coin1", 10, 1'b0);
    coin_pulse("coin2", 10, 1'b0);
    check_outputs("two_coins", 0);

    coin_pulse("coin3", 10, 1'b0);
    vend_pulse("vend1");
    vend_pulse("vend_under");

    coin_pulse("coin4", 10, 1'b0);
    coin_pulse("simul", 10, 1'b1);
    check_outputs("simul", 0);

    clear_pulse("clear0");
    for (int i = 0; i < 6; i++) coin_pulse("sat", 10, 1'b0);
    check_outputs("sat", 0);
    clear_pulse("clear_sat");

    @(negedge clock);
    bus.coin_in = 1'b1;
    k = cyc + 1;
    expect_coin(k, 1'b0);
    repeat (35) @(negedge clock);
    check_outputs("jammed", 1);
    repeat (5) @(negedge clock);
    bus.coin_in = 1'b0;
    repeat (8) @(negedge clock);
    check_outputs("unjam", 0);
    check_eq("jam_evt_pending", sb.size(), 0);

    @(negedge clock);
    bus.coin_in = 1'b1;
    k = cyc + 1;
    expect_coin(k, 1'b0);
    repeat (35) @(negedge clock);
    check_outputs("jam2", 1);
    #2;
    reset = 1'b1;
    m_credit = 0;
    #1;
    check_outputs("async_rst", 0);
    check_eq("async_rst_evt", int'(bus.coin_event), 0);
    @(negedge clock);
    reset = 1'b0;
    k = cyc + 1;
    expect_coin(k, 1'b0);
    repeat (10) @(negedge clock);
    bus.coin_in = 1'b0;
    repeat (8) @(negedge clock);
    check_outputs("post_rst", 0);
    check_eq("post_rst_evt_pending", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
